// File: rtl/latch_bank.sv
// CH independent W-bit channels that follow, capture-and-lock or OR-accumulate their data under one global mode.
// One-cycle registered latency on Q/V/OVF; no backpressure, every cycle accepts new inputs.
module latch_bank #(
   parameter int W  = 8,
   parameter int CH = 4
) (
   input  logic            CLK,
   input  logic            R,
   input  logic [1:0]      MODE,
   input  logic [CH*W-1:0] D,
   input  logic [CH-1:0]   E,
   input  logic [CH-1:0]   S,
   input  logic [CH-1:0]   REL,
   output logic [CH*W-1:0] Q,
   output logic [CH-1:0]   V,
   output logic [CH-1:0]   OVF
);

   typedef enum logic [1:0] {
      M_TRANS  = 2'b00,
      M_CAP    = 2'b01,
      M_STICKY = 2'b10,
      M_HOLD   = 2'b11
   } mode_t;

   typedef enum logic {
      OPEN = 1'b0,
      HELD = 1'b1
   } state_t;

   state_t st [CH];

   always_ff @(posedge CLK) begin
      if (!R) begin
         Q   <= '0;
         V   <= '0;
         OVF <= '0;
         for (int i = 0; i < CH; i++) st[i] <= OPEN;
      end else if (MODE != M_HOLD) begin
         for (int i = 0; i < CH; i++) begin
            if (MODE == M_CAP) begin
               // Set outranks release and overflow, and (re)locks the channel.
               if (E[i] && !S[i]) begin
                  Q[i*W +: W] <= '1;
                  V[i]        <= 1'b1;
                  st[i]       <= HELD;
               end else if (st[i] == HELD) begin
                  if (REL[i]) begin
                     st[i]  <= OPEN;
                     V[i]   <= 1'b0;
                     OVF[i] <= 1'b0;
                  end else if (E[i]) begin
                     OVF[i] <= 1'b1;
                  end
               end else if (E[i]) begin
                  Q[i*W +: W] <= D[i*W +: W];
                  V[i]        <= 1'b1;
                  st[i]       <= HELD;
               end
            end else begin
               // Outside capture the lock is dropped; OVF survives until reset or release.
               st[i] <= OPEN;
               V[i]  <= 1'b0;
               if (E[i] && !S[i])
                  Q[i*W +: W] <= '1;
               else if (E[i] && MODE == M_TRANS)
                  Q[i*W +: W] <= D[i*W +: W];
               else if (E[i])
                  Q[i*W +: W] <= Q[i*W +: W] | D[i*W +: W];
            end
         end
      end
   end

endmodule
